adder_fu_issuer: RTL and testbench
==================================

Name: adder_fu_issuer

Overview:
- Initiator side of the adder FU handshake (a/b/on_off out, c/carry_out/ack in), instantiated beside the adder FU in each v_tile.
- Buffers operand pairs arriving from the tile interconnect in a small FIFO.
- Issues each pair to the FU, waits for ack with a timeout, and presents the captured sum/carry downstream under valid/ready.

Parameters:
WIDTH, 16, operand/result bit width; must match the FU width
DEPTH, 4, operand FIFO entries (power of two, >=2)
TIMEOUT, 8, max BUSY cycles waiting for fu_ack before an error result is produced (>=2)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair offered
in_ready  output  1  FIFO can accept (= !full)
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
fu_a  output  WIDTH  operand A to FU (registered)
fu_b  output  WIDTH  operand B to FU (registered)
fu_on_off  output  1  FU enable (registered)
fu_c  input  WIDTH  FU sum
fu_carry_out  input  1  FU carry
fu_ack  input  1  FU result valid
res_valid  output  1  result held for consumer
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured sum (0 on error)
res_carry  output  1  captured carry (0 on error)
res_err  output  1  result produced by timeout, not by ack
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values: fu_a=0, fu_b=0, fu_on_off=0, res_valid=0, res_data=0, res_carry=0, res_err=0, busy=0, FIFO empty (in_ready=1), timeout counter=0, state=IDLE.
- Reset mid-operation discards the FIFO contents, any in-flight issue and any held result.
- FU contract: registered. With on_off=1 sampled at edge k, c/carry_out/ack are valid after edge k. With on_off=0, all FU outputs are 0.
- FIFO:
  - Push on in_valid && in_ready.
  - Pop only on the BUSY->RESULT transition.
  - When full, in_ready=0 with no push-through bypass, even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full leave the count unchanged.
  - Pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits.
- FSM:
  - IDLE:
    - fu_on_off=0, fu_a=fu_b=0.
    - If FIFO not empty: load fu_a/fu_b from the FIFO head, set fu_on_off=1, clear the counter, go BUSY.
  - BUSY:
    - fu_a, fu_b, fu_on_off held stable. Counter increments each cycle.
    - fu_ack=1: capture fu_c->res_data, fu_carry_out->res_carry, res_err=0, res_valid=1, pop FIFO, fu_on_off=0, go RESULT.
    - Else if counter==TIMEOUT-1: res_data=0, res_carry=0, res_err=1, res_valid=1, pop FIFO, fu_on_off=0, go RESULT.
  - RESULT:
    - res_valid=1; res_data, res_carry and res_err are held stable until res_ready=1.
    - On res_ready: res_valid=0, go IDLE.
- Stale-ack guard: fu_on_off is low for at least the RESULT and IDLE cycles between issues. An ack seen in BUSY therefore always belongs to the current operands.
- Latency: a pair at the FIFO head with state IDLE at edge k, and an FU acking after one cycle, gives res_valid=1 after edge k+2.
- Throughput: one result per 4 cycles with res_ready tied high.
- Arithmetic is performed in the FU only; the issuer does no arithmetic on the data path.
- fu_ack arriving in IDLE or RESULT is ignored.
- Timeout and ack in the same cycle: ack wins.

Decomposition:
- Package cgra_fu_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, RESULT} fu_issuer_state_t
  - the default width/depth/timeout localparams shared with the FU and the tile top.
- Natural sub-module: fu_operand_fifo, a synchronous FIFO (WIDTH*2 data, DEPTH, async active-high reset, full/empty/count outputs).
- The FSM and result register stay in adder_fu_issuer.

Test Plan:
- Push a=000A, b=0005 with res_ready=1 into a half_adder DUT -> res_valid after 3 cycles from IDLE, res_data=000F, res_carry=0, res_err=0.
- Push FFFF+0001 then 8000+8000 back-to-back -> two results in order: 0000/carry 1, then 0000/carry 1. fu_on_off drops to 0 between the two issues.
- Hold res_ready=0 and push 5 pairs -> in_ready=0 once 4 entries are buffered (first pair in BUSY/RESULT is already popped, so the FIFO fills at pairs 2..5). res_data stays stable until res_ready=1.
- Replace the FU with a stub that never asserts fu_ack, push 1234+0001 -> after 8 BUSY cycles res_valid=1, res_err=1, res_data=0000. The next pair then issues normally.
- Assert reset for 1 cycle while BUSY with 2 pairs queued -> fu_on_off=0, in_ready=1, res_valid=0 immediately (asynchronous). No result is emitted for the discarded pairs.
- Push 0000+0000 -> res_data=0000, res_carry=0, res_err=0, proving zero results are distinguishable from errors via res_err.

Source files
------------

// File: rtl/cgra_fu_pkg.sv
// Shared types and default sizing for the CGRA adder FU, its issuer and the tile top.
package cgra_fu_pkg;

  localparam int FU_WIDTH   = 16;
  localparam int FU_DEPTH   = 4;
  localparam int FU_TIMEOUT = 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESULT
  } fu_issuer_state_t;

endpackage

// File: rtl/fu_operand_fifo.sv
// Synchronous operand-pair FIFO. Full blocks pushes even when a pop happens in the
// same cycle, so the upstream ready never depends on the downstream pop.
module fu_operand_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DW-1:0]              din,
  input  logic                       pop,
  output logic [DW-1:0]              dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers, cleared by reset so queued pairs are discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/adder_fu_issuer.sv
// Issues buffered operand pairs to the adder FU, waits for ack with a timeout,
// and holds the captured result for the consumer under valid/ready.
//
// state  | meaning
// IDLE   | FU disabled, operands zero; issue FIFO head when available
// BUSY   | operands held on FU, counting cycles until ack or timeout
// RESULT | result held on res_* until res_ready
module adder_fu_issuer
  import cgra_fu_pkg::*;
#(
  parameter int WIDTH   = FU_WIDTH,
  parameter int DEPTH   = FU_DEPTH,
  parameter int TIMEOUT = FU_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] fu_a,
  output logic [WIDTH-1:0] fu_b,
  output logic             fu_on_off,
  input  logic [WIDTH-1:0] fu_c,
  input  logic             fu_carry_out,
  input  logic             fu_ack,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_carry,
  output logic             res_err,
  output logic             busy
);

  localparam int CW = $clog2(TIMEOUT);

  fu_issuer_state_t   state_q, state_d;
  logic [WIDTH-1:0]   fu_a_q, fu_a_d, fu_b_q, fu_b_d;
  logic               fu_on_off_q, fu_on_off_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;
  logic               res_carry_q, res_carry_d;
  logic               res_err_q, res_err_d;

  logic [2*WIDTH-1:0]     fifo_head;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(DEPTH):0] fifo_count_unused;

  fu_operand_fifo #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (in_valid && in_ready),
    .din   ({in_a, in_b}),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count_unused)
  );

  assign in_ready  = !fifo_full;
  assign fu_a      = fu_a_q;
  assign fu_b      = fu_b_q;
  assign fu_on_off = fu_on_off_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_carry = res_carry_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != IDLE);

  // Next-state, FU drive and result capture. Leaving BUSY drops fu_on_off, so the
  // FU is idle through RESULT and IDLE and any ack seen in BUSY is for these operands.
  always_comb begin
    state_d     = state_q;
    fu_a_d      = fu_a_q;
    fu_b_d      = fu_b_q;
    fu_on_off_d = fu_on_off_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    fifo_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        fu_on_off_d = 1'b0;
        fu_a_d      = '0;
        fu_b_d      = '0;
        if (!fifo_empty) begin
          fu_a_d      = fifo_head[2*WIDTH-1:WIDTH];
          fu_b_d      = fifo_head[WIDTH-1:0];
          fu_on_off_d = 1'b1;
          cnt_d       = '0;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (fu_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
          res_data_d  = fu_ack ? fu_c : '0;
          res_carry_d = fu_ack ? fu_carry_out : 1'b0;
          res_err_d   = !fu_ack;
          res_valid_d = 1'b1;
          fifo_pop    = 1'b1;
          fu_on_off_d = 1'b0;
          fu_a_d      = '0;
          fu_b_d      = '0;
          state_d     = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, FU interface and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      fu_a_q      <= '0;
      fu_b_q      <= '0;
      fu_on_off_q <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fu_a_q      <= fu_a_d;
      fu_b_q      <= fu_b_d;
      fu_on_off_q <= fu_on_off_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
    end
  end

endmodule

// File: tb/tb_adder_fu_issuer.sv
// Bench for adder_fu_issuer with a registered adder FU model and a result scoreboard.
module tb_adder_fu_issuer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] in_a, in_b;
  logic [W-1:0] fu_a, fu_b;
  logic         fu_on_off;
  logic [W-1:0] fu_c = '0;
  logic         fu_carry_out = 1'b0;
  logic         fu_ack = 1'b0;
  logic         res_valid, res_ready;
  logic [W-1:0] res_data;
  logic         res_carry, res_err, busy;

  bit stub = 1'b0;

  typedef struct {
    logic [W-1:0] d;
    logic         c;
    logic         e;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   rises = 0;
  logic prev_on = 1'b0;

  adder_fu_issuer dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .fu_a         (fu_a),
    .fu_b         (fu_b),
    .fu_on_off    (fu_on_off),
    .fu_c         (fu_c),
    .fu_carry_out (fu_carry_out),
    .fu_ack       (fu_ack),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_err      (res_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Registered adder FU; the stub never acknowledges.
  always @(posedge clk) begin
    if (fu_on_off) begin
      {fu_carry_out, fu_c} <= {1'b0, fu_a} + {1'b0, fu_b};
      fu_ack               <= !stub;
    end else begin
      fu_c         <= '0;
      fu_carry_out <= 1'b0;
      fu_ack       <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input bit no_ack);
    exp_t r;
    int unsigned s;
    s = int'(a) + int'(b);
    if (no_ack) begin
      r.d = '0; r.c = 1'b0; r.e = 1'b1;
    end else begin
      r.d = W'(s % 65536); r.c = (s >= 65536); r.e = 1'b0;
    end
    return r;
  endfunction

  // One clock: record handshakes seen before the edge, then advance to edge+1.
  task automatic tick();
    bit   pushed, taken;
    exp_t e;
    pushed = in_valid && in_ready;
    taken  = res_valid && res_ready;
    if (taken) begin
      if (q.size() == 0) chk("unexpected_result", 32'(res_data), 32'hdead);
      else begin
        e = q.pop_front();
        chk("res_data",  32'(res_data),  32'(e.d));
        chk("res_carry", 32'(res_carry), 32'(e.c));
        chk("res_err",   32'(res_err),   32'(e.e));
      end
    end
    if (pushed) q.push_back(model(in_a, in_b, stub));
    @(posedge clk);
    #1;
    if (fu_on_off && !prev_on) rises++;
    prev_on = fu_on_off;
  endtask

  task automatic push1(input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!res_valid && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    res_ready = 1'b1;
    in_valid  = 1'b0;
    while ((q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 32'(q.size() != 0 || busy), 32'd0);
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; res_ready = 1'b0;
    #1;
    chk("rst_fu_a",      32'(fu_a),      32'd0);
    chk("rst_fu_b",      32'(fu_b),      32'd0);
    chk("rst_fu_on_off", 32'(fu_on_off), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);
    chk("rst_res_carry", 32'(res_carry), 32'd0);
    chk("rst_res_err",   32'(res_err),   32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // Latency and basic sum.
    res_ready = 1'b1;
    push1(16'h000A, 16'h0005);
    wait_valid(20, n);
    chk("latency", 32'(n), 32'd3);
    chk("sum_000F", 32'(res_data), 32'h000F);
    tick();

    // Back-to-back carries; the FU must be disabled between the two issues.
    rises = 0;
    push1(16'hFFFF, 16'h0001);
    push1(16'h8000, 16'h8000);
    for (int i = 0; i < 12; i++) tick();
    chk("b2b_issues", 32'(rises), 32'd2);
    chk("b2b_done",   32'(q.size()), 32'd0);

    // Backpressure: FIFO fills while the first result is held.
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom);
      tick();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_queued",   32'(q.size()), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("hold_valid",    32'(res_valid), 32'd1);
      chk("hold_data",     32'(res_data),  32'(q[0].d));
      chk("hold_in_ready", 32'(in_ready),  32'd0);
      tick();
    end
    drain("drain_full");

    // Timeout with a non-acking FU, then a normal issue.
    stub = 1'b1;
    push1(16'h1234, 16'h0001);
    wait_valid(30, n);
    chk("timeout_cycles", 32'(n), 32'd9);
    chk("timeout_err",    32'(res_err),  32'd1);
    chk("timeout_data",   32'(res_data), 32'd0);
    tick();
    stub = 1'b0;
    push1(16'h0101, 16'h0202);
    wait_valid(20, n);
    chk("after_timeout_err", 32'(res_err), 32'd0);
    drain("drain_timeout");

    // Asynchronous reset while BUSY with pairs queued.
    push1(16'h1111, 16'h2222);
    push1(16'h3333, 16'h4444);
    push1(16'h5555, 16'h6666);
    chk("pre_reset_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_fu_on_off", 32'(fu_on_off), 32'd0);
    chk("arst_in_ready",  32'(in_ready),  32'd1);
    chk("arst_res_valid", 32'(res_valid), 32'd0);
    chk("arst_busy",      32'(busy),      32'd0);
    q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    prev_on = fu_on_off;
    for (int i = 0; i < 10; i++) tick();
    chk("no_stale_issue", 32'(busy), 32'd0);

    // Zero result distinguished from error.
    push1(16'h0000, 16'h0000);
    wait_valid(20, n);
    chk("zero_valid", 32'(res_valid), 32'd1);
    chk("zero_err",   32'(res_err),   32'd0);
    chk("zero_data",  32'(res_data),  32'd0);
    drain("drain_zero");

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = W'($urandom);
      in_b      = W'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("drain_random");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
